// File: rtl/logic_arbiter_if.sv
// Requester / response bundle for logic_arbiter.
// master: requesters and consumer; slave: the arbiter.
interface logic_arbiter_if;
  logic       i_req0_valid;
  logic [7:0] i_req0_a;
  logic [7:0] i_req0_b;
  logic [1:0] i_req0_instr;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [7:0] i_req1_a;
  logic [7:0] i_req1_b;
  logic [1:0] i_req1_instr;
  logic       o_req1_ready;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_data;
  logic       o_rsp_id;
  logic       i_rsp_ready;
  logic       o_busy;

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_instr,
    input  o_req0_ready,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_instr,
    input  o_req1_ready,
    input  o_rsp_valid, o_rsp_data, o_rsp_id,
    output i_rsp_ready,
    input  o_busy
  );

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_instr,
    output o_req0_ready,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_instr,
    output o_req1_ready,
    output o_rsp_valid, o_rsp_data, o_rsp_id,
    input  i_rsp_ready,
    output o_busy
  );
endinterface

// File: rtl/logic_arbiter.sv
// Two-requester arbiter sharing one bitwise logic_engine.
// Define LOGIC_ARBITER_FAIR_EN for round-robin, else req0 wins.
module logic_engine (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [1:0] instr_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = '0;
    unique case (instr_i)
      2'b00: y_o = a_i | b_i;
      2'b01: y_o = ~(a_i & b_i);
      2'b10: y_o = ~(a_i | b_i);
      2'b11: y_o = a_i & b_i;
      default: y_o = '0;
    endcase
  end
endmodule

module logic_arbiter (
  input logic          i_clk,
  input logic          i_rst_n,
  logic_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [1:0] instr_q, instr_d;
  logic       id_q, id_d;
  logic [7:0] data_q, data_d;
  logic [7:0] eng_y;
  logic       v0, v1;
  logic       gnt0, gnt1;
  logic       rdy0, rdy1;
  logic       rsp_vld;

  assign v0 = bus.i_req0_valid;
  assign v1 = bus.i_req1_valid;

`ifdef LOGIC_ARBITER_FAIR_EN
  logic ptr_q, ptr_d;

  // On contention the requester not served last wins.
  assign gnt0 = v0 & (~v1 | ptr_q);
  assign gnt1 = v1 & (~v0 | ~ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && (gnt0 | gnt1))
      ptr_d = gnt1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 1'b1;
    else          ptr_q <= ptr_d;
  end
`else
  assign gnt0 = v0;
  assign gnt1 = v1 & ~v0;
`endif

  logic_engine u_eng (
    .a_i    (a_q),
    .b_i    (b_q),
    .instr_i(instr_q),
    .y_o    (eng_y)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    instr_d = instr_q;
    id_d    = id_q;
    data_d  = data_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    rsp_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = gnt0;
        rdy1 = gnt1;
        if (gnt0 | gnt1) begin
          a_d     = gnt1 ? bus.i_req1_a : bus.i_req0_a;
          b_d     = gnt1 ? bus.i_req1_b : bus.i_req0_b;
          instr_d = gnt1 ? bus.i_req1_instr
                         : bus.i_req0_instr;
          id_d    = gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = eng_y;
        state_d = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        if (bus.i_rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      instr_q <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      instr_q <= instr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_req0_ready = rdy0;
  assign bus.o_req1_ready = rdy1;
  assign bus.o_rsp_valid  = rsp_vld;
  assign bus.o_rsp_data   = data_q;
  assign bus.o_rsp_id     = id_q;
  assign bus.o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_logic_arbiter.sv
// Randomized scoreboard bench for logic_arbiter.
// Reference model works per transaction phase, not per RTL state.
module tb_logic_arbiter;
  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } rsp_t;

`ifdef LOGIC_ARBITER_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_arbiter_if bus ();

  logic_arbiter dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  rsp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   phase = 0;
  logic last = 1'b1;

  function automatic logic [7:0] ref_op(
    input logic [7:0] a, input logic [7:0] b,
    input logic [1:0] op);
    case (op)
      2'd0: return a | b;
      2'd1: return ~(a & b);
      2'd2: return ~(a | b);
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", n, got, exp);
  endtask

  task automatic cycle(
    input logic v0, input logic v1,
    input logic [7:0] a0, input logic [7:0] b0,
    input logic [1:0] o0,
    input logic [7:0] a1, input logic [7:0] b1,
    input logic [1:0] o1, input logic rr);
    int   nxt;
    logic g0, g1;
    @(negedge clk);
    bus.i_req0_valid = v0;
    bus.i_req0_a     = a0;
    bus.i_req0_b     = b0;
    bus.i_req0_instr = o0;
    bus.i_req1_valid = v1;
    bus.i_req1_a     = a1;
    bus.i_req1_b     = b1;
    bus.i_req1_instr = o1;
    bus.i_rsp_ready  = rr;
    #1;
    nxt = phase;
    if (phase == 0) begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (v0 && v1) begin
        if (FAIR && last == 1'b0) g1 = 1'b1;
        else g0 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
      chk("idle_rdy0", bus.o_req0_ready, g0);
      chk("idle_rdy1", bus.o_req1_ready, g1);
      chk("idle_busy", bus.o_busy, 0);
      chk("idle_rspv", bus.o_rsp_valid, 0);
      if (g0 || g1) begin
        sb.push_back(g1 ? rsp_t'{1'b1, ref_op(a1, b1, o1)}
                        : rsp_t'{1'b0, ref_op(a0, b0, o0)});
        last = g1;
        nxt  = 1;
      end
    end else begin
      chk("busy_rdy0", bus.o_req0_ready, 0);
      chk("busy_rdy1", bus.o_req1_ready, 0);
      chk("busy_busy", bus.o_busy, 1);
      chk("busy_rspv", bus.o_rsp_valid, phase == 2);
      if (phase == 1) nxt = 2;
      else if (rr) nxt = 0;
    end
    @(posedge clk);
    phase = nxt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rnd_cycle(input logic v0, input logic v1,
                           input logic rr);
    cycle(v0, v1,
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          2'($urandom_range(0, 3)), rr);
  endtask

  task automatic reset_vals(input string n);
    chk({n, "_rspv"}, bus.o_rsp_valid, 0);
    chk({n, "_data"}, bus.o_rsp_data, 0);
    chk({n, "_id"}, bus.o_rsp_id, 0);
    chk({n, "_busy"}, bus.o_busy, 0);
    chk({n, "_rdy0"}, bus.o_req0_ready, 0);
  endtask

  // Monitor: compare every presented response with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.o_rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_orphan", 1, 0);
        end else begin
          chk("rsp_data", bus.o_rsp_data, sb[0].data);
          chk("rsp_id", bus.o_rsp_id, sb[0].id);
          if (bus.i_rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] k0;
    logic [7:0] k1;
    k0 = 8'hAA;
    k1 = 8'h0F;
    bus.i_req0_valid = 0;
    bus.i_req0_a     = 0;
    bus.i_req0_b     = 0;
    bus.i_req0_instr = 0;
    bus.i_req1_valid = 0;
    bus.i_req1_a     = 0;
    bus.i_req1_b     = 0;
    bus.i_req1_instr = 0;
    bus.i_rsp_ready  = 0;
    #1;
    reset_vals("rst");
    #2 rst_n = 1'b1;

    cycle(1, 0, 8'hF0, 8'h3C, 2'd0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int op = 0; op < 4; op++) begin
      if (op[0]) cycle(0, 1, 0, 0, 0, k0, k1, 2'(op), 1);
      else       cycle(1, 0, k0, k1, 2'(op), 0, 0, 0, 1);
      idle(2);
    end

    for (int i = 0; i < 12; i++) rnd_cycle(1, 1, 1);
    idle(3);

    rnd_cycle(1, 1, 0);
    rnd_cycle(1, 1, 0);
    for (int i = 0; i < 5; i++) rnd_cycle(1, 1, 0);
    rnd_cycle(0, 0, 1);
    idle(2);

    cycle(1, 0, 8'h5A, 8'hC3, 2'd0, 0, 0, 0, 1);
    #2;
    bus.i_req0_valid = 0;
    bus.i_req1_valid = 0;
    rst_n = 1'b0;
    #1;
    reset_vals("rst_mid");
    sb.delete();
    phase = 0;
    last  = 1'b1;
    #1 rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 400; i++)
      rnd_cycle(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 6);
    idle(4);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
